// File: rtl/ddr5_dram_cmd_responder.sv
// DRAM-side DDR5 command responder for one bank group: per-bank state, timing checks, read/write strobes.
// Optional feature macro DDR5_DROP_ILLEGAL_EN: violating commands are flagged and then discarded.
module ddr5_dram_cmd_responder #(
  parameter int NUM_BANKS   = 4,
  parameter int ROW_W       = 16,
  parameter int RDQ_DEPTH   = 8,
  parameter int T_RC        = 228,
  parameter int T_RAS       = 152,
  parameter int T_RRD_L     = 22,
  parameter int T_RP        = 76,
  parameter int T_RCD       = 76,
  parameter int T_CL        = 80,
  parameter int T_CWD       = 76,
  parameter int T_WR        = 60,
  parameter int T_RTP       = 36,
  parameter int T_BURST     = 16,
  parameter int T_CCD_L     = 22,
  parameter int T_CCD_L_WR  = 94,
  parameter int T_CCD_L_RTW = 30,
  parameter int T_CCD_L_WTR = 138
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  input  logic [ROW_W-1:0]             cmd_row,
  output logic                         rd_data_valid,
  output logic                         wr_done,
  output logic                         viol,
  output logic [3:0]                   viol_code,
  output logic [NUM_BANKS-1:0]         bank_open,
  output logic                         rdq_overflow
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int QA_W   = $clog2(RDQ_DEPTH);
  localparam int WR_LAT = T_CWD + T_BURST - 1;
  localparam logic [1:0] OP_ACT = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_PRE = 2'd3;

  typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} bank_state_t;

  bank_state_t      bank_st     [NUM_BANKS];
  bank_state_t      bank_st_nxt [NUM_BANKS];
  logic [ROW_W-1:0] open_row    [NUM_BANKS];
  logic [9:0]       cnt_act [NUM_BANKS];
  logic [9:0]       cnt_pre [NUM_BANKS];
  logic [9:0]       cnt_rd  [NUM_BANKS];
  logic [9:0]       cnt_wr  [NUM_BANKS];
  logic [9:0]       g_act, g_rd, g_wr;
  logic [15:0]      ts;

  logic is_act, is_rd, is_wr, is_pre, exec;
  logic [3:0] code;

  // Counters hold (cycles since event - 1); elapsed time is therefore cnt + 1.
  function automatic logic met(input logic [9:0] cnt, input int t_req);
    return ({1'b0, cnt} + 11'd1) >= 11'(t_req);
  endfunction

  function automatic logic [9:0] sat_inc(input logic [9:0] c);
    return (c == 10'h3FF) ? c : c + 10'd1;
  endfunction

  assign is_act = cmd_valid && (cmd_op == OP_ACT);
  assign is_rd  = cmd_valid && (cmd_op == OP_RD);
  assign is_wr  = cmd_valid && (cmd_op == OP_WR);
  assign is_pre = cmd_valid && (cmd_op == OP_PRE);

  // Checks are ordered so the lowest applicable code is reported.
  always_comb begin
    code = 4'd0;
    if (is_act) begin
      if (bank_st[cmd_bank] == OPEN)                 code = 4'd1;
      else if (!met(cnt_pre[cmd_bank], T_RP))        code = 4'd3;
      else if (!met(cnt_act[cmd_bank], T_RC))        code = 4'd4;
      else if (!met(g_act, T_RRD_L))                 code = 4'd5;
    end else if (is_rd || is_wr) begin
      if (bank_st[cmd_bank] == CLOSED)               code = 4'd2;
      else if (!met(cnt_act[cmd_bank], T_RCD))       code = 4'd6;
      else if (is_rd && !met(g_rd, T_CCD_L))         code = 4'd7;
      else if (is_wr && !met(g_wr, T_CCD_L_WR))      code = 4'd8;
      else if (is_wr && !met(g_rd, T_CCD_L_RTW))     code = 4'd9;
      else if (is_rd && !met(g_wr, T_CCD_L_WTR))     code = 4'd10;
    end else if (is_pre && (bank_st[cmd_bank] == OPEN)) begin
      if (!met(cnt_act[cmd_bank], T_RAS))            code = 4'd11;
      else if (!met(cnt_rd[cmd_bank], T_RTP))        code = 4'd12;
      else if (!met(cnt_wr[cmd_bank], T_CWD + T_BURST + T_WR)) code = 4'd13;
    end
  end

`ifdef DDR5_DROP_ILLEGAL_EN
  assign exec = (code == 4'd0);
`else
  assign exec = 1'b1;
`endif

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_st_nxt[i] = bank_st[i];
      if (exec && (cmd_bank == BANK_W'(i))) begin
        if (is_act)      bank_st_nxt[i] = OPEN;
        else if (is_pre) bank_st_nxt[i] = CLOSED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_st[i]  <= CLOSED;
        open_row[i] <= '0;
        cnt_act[i]  <= 10'h3FF;
        cnt_pre[i]  <= 10'h3FF;
        cnt_rd[i]   <= 10'h3FF;
        cnt_wr[i]   <= 10'h3FF;
      end
      g_act <= 10'h3FF;
      g_rd  <= 10'h3FF;
      g_wr  <= 10'h3FF;
      ts    <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_st[i] <= bank_st_nxt[i];
        if (exec && is_act && (cmd_bank == BANK_W'(i))) open_row[i] <= cmd_row;
        cnt_act[i] <= (exec && is_act && (cmd_bank == BANK_W'(i))) ? 10'd0 : sat_inc(cnt_act[i]);
        cnt_rd[i]  <= (exec && is_rd  && (cmd_bank == BANK_W'(i))) ? 10'd0 : sat_inc(cnt_rd[i]);
        cnt_wr[i]  <= (exec && is_wr  && (cmd_bank == BANK_W'(i))) ? 10'd0 : sat_inc(cnt_wr[i]);
        // PRE to an already closed bank is a no-op and leaves tRP history alone.
        cnt_pre[i] <= (exec && is_pre && (cmd_bank == BANK_W'(i)) && (bank_st[i] == OPEN))
                      ? 10'd0 : sat_inc(cnt_pre[i]);
      end
      g_act <= (exec && is_act) ? 10'd0 : sat_inc(g_act);
      g_rd  <= (exec && is_rd)  ? 10'd0 : sat_inc(g_rd);
      g_wr  <= (exec && is_wr)  ? 10'd0 : sat_inc(g_wr);
      ts    <= ts + 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) bank_open[i] = (bank_st[i] == OPEN);
  end

  // Read tracker: FIFO of due timestamps, popped when the free-running stamp reaches the head.
  logic [15:0]     rdq_mem [RDQ_DEPTH];
  logic [QA_W-1:0] rdq_wp, rdq_rp;
  logic [QA_W:0]   rdq_cnt;
  logic            rd_push, rd_pop, rdq_full, rd_push_ok;

  assign rd_push    = exec && is_rd;
  assign rd_pop     = (rdq_cnt != '0) && (rdq_mem[rdq_rp] == ts);
  assign rdq_full   = (rdq_cnt == (QA_W+1)'(RDQ_DEPTH));
  assign rd_push_ok = rd_push && (!rdq_full || rd_pop);

  always_ff @(posedge clk) begin
    if (rd_push_ok) rdq_mem[rdq_wp] <= ts + 16'(T_CL);
  end

  // Write tracker: same structure, sized alike.
  logic [15:0]     wrq_mem [RDQ_DEPTH];
  logic [QA_W-1:0] wrq_wp, wrq_rp;
  logic [QA_W:0]   wrq_cnt;
  logic            wr_push_ok, wr_pop;

  assign wr_pop     = (wrq_cnt != '0) && (wrq_mem[wrq_rp] == ts);
  assign wr_push_ok = exec && is_wr && ((wrq_cnt != (QA_W+1)'(RDQ_DEPTH)) || wr_pop);

  always_ff @(posedge clk) begin
    if (wr_push_ok) wrq_mem[wrq_wp] <= ts + 16'(WR_LAT);
  end

  logic [11:0] burst_cnt, burst_rem;
  assign burst_rem     = (burst_cnt == '0) ? 12'd0 : burst_cnt - 12'd1;
  assign rd_data_valid = (burst_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdq_wp <= '0; rdq_rp <= '0; rdq_cnt <= '0;
      wrq_wp <= '0; wrq_rp <= '0; wrq_cnt <= '0;
      burst_cnt    <= '0;
      wr_done      <= 1'b0;
      viol         <= 1'b0;
      viol_code    <= 4'd0;
      rdq_overflow <= 1'b0;
    end else begin
      if (rd_push_ok) rdq_wp <= rdq_wp + 1'b1;
      if (rd_pop)     rdq_rp <= rdq_rp + 1'b1;
      rdq_cnt <= rdq_cnt + (QA_W+1)'(rd_push_ok) - (QA_W+1)'(rd_pop);
      if (wr_push_ok) wrq_wp <= wrq_wp + 1'b1;
      if (wr_pop)     wrq_rp <= wrq_rp + 1'b1;
      wrq_cnt <= wrq_cnt + (QA_W+1)'(wr_push_ok) - (QA_W+1)'(wr_pop);
      // A burst popped while another is still on the bus queues behind it.
      if (rd_pop)
        burst_cnt <= (burst_rem > (12'hFFF - 12'(T_BURST))) ? 12'hFFF : burst_rem + 12'(T_BURST);
      else
        burst_cnt <= burst_rem;
      wr_done <= wr_pop;
      viol    <= (code != 4'd0);
      if (code != 4'd0) viol_code <= code;
      if (rd_push && rdq_full && !rd_pop) rdq_overflow <= 1'b1;
    end
  end

  a_open_row_known: assert property (@(posedge clk) disable iff (rst)
    ((is_rd || is_wr) && (bank_st[cmd_bank] == OPEN)) |-> !$isunknown(open_row[cmd_bank]));

endmodule

// File: tb/tb_ddr5_dram_cmd_responder.sv
// Bench for ddr5_dram_cmd_responder: directed scenarios plus random traffic against an event-time model.
module tb_ddr5_dram_cmd_responder;

  localparam int NB = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_bank = 2'd0;
  logic [15:0] cmd_row = 16'd0;
  logic        rd_data_valid, wr_done, viol, rdq_overflow;
  logic [3:0]  viol_code, bank_open;
  logic [11:0] obs;

  ddr5_dram_cmd_responder dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .rd_data_valid(rd_data_valid), .wr_done(wr_done), .viol(viol),
    .viol_code(viol_code), .bank_open(bank_open), .rdq_overflow(rdq_overflow)
  );

  always #5 clk = ~clk;
  assign obs = {rd_data_valid, wr_done, viol, viol_code, bank_open, rdq_overflow};

  // Reference model: absolute event times, spec timing rules, queues of due cycles.
  int cyc, n_vec, n_err;
  int last_act[NB], last_pre[NB], last_rd[NB], last_wr[NB];
  int g_act, g_rd, g_wr, data_end;
  bit m_open[NB];
  bit exp_viol, exp_ovf;
  int exp_code;
  int rd_starts[$];
  logic [31:0] exp_q[$];
  int wr_q[$];

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      last_act[i] = -100000; last_pre[i] = -100000;
      last_rd[i] = -100000;  last_wr[i] = -100000;
      m_open[i] = 0;
    end
    g_act = -100000; g_rd = -100000; g_wr = -100000;
    data_end = 0; exp_viol = 0; exp_ovf = 0; exp_code = 0; cyc = 0;
    rd_starts.delete(); exp_q.delete(); wr_q.delete();
  endfunction

  function automatic int model_code(int op, int b);
    int t = cyc;
    case (op)
      0: begin
        if (m_open[b]) return 1;
        if (t - last_pre[b] < 76) return 3;
        if (t - last_act[b] < 228) return 4;
        if (t - g_act < 22) return 5;
      end
      1, 2: begin
        if (!m_open[b]) return 2;
        if (t - last_act[b] < 76) return 6;
        if (op == 1 && t - g_rd < 22) return 7;
        if (op == 2 && t - g_wr < 94) return 8;
        if (op == 2 && t - g_rd < 30) return 9;
        if (op == 1 && t - g_wr < 138) return 10;
      end
      default: if (m_open[b]) begin
        if (t - last_act[b] < 152) return 11;
        if (t - last_rd[b] < 36) return 12;
        if (t - last_wr[b] < 76 + 16 + 60) return 13;
      end
    endcase
    return 0;
  endfunction

  function automatic void model_apply(bit v, int op, int b);
    int code, s, beg;
    bit do_exec;
    exp_viol = 0;
    if (!v) return;
    code = model_code(op, b);
    if (code != 0) begin exp_viol = 1; exp_code = code; end
`ifdef DDR5_DROP_ILLEGAL_EN
    do_exec = (code == 0);
`else
    do_exec = 1;
`endif
    if (!do_exec) return;
    case (op)
      0: begin m_open[b] = 1; last_act[b] = cyc; g_act = cyc; end
      1: begin
        last_rd[b] = cyc; g_rd = cyc;
        s = cyc + 1 + 80;
        while (rd_starts.size() != 0 && rd_starts[0] <= cyc + 1) void'(rd_starts.pop_front());
        if (rd_starts.size() == DEPTH) exp_ovf = 1;
        else begin
          rd_starts.push_back(s);
          beg = (s > data_end) ? s : data_end;
          exp_q.push_back(32'(beg));
          data_end = beg + 16;
        end
      end
      2: begin last_wr[b] = cyc; g_wr = cyc; wr_q.push_back(cyc + 76 + 16); end
      default: if (m_open[b]) begin m_open[b] = 0; last_pre[b] = cyc; end
    endcase
  endfunction

  function automatic logic [11:0] exp_vec();
    logic rdv, wrd;
    logic [3:0] bo;
    while (exp_q.size() != 0 && int'(exp_q[0]) + 16 <= cyc) void'(exp_q.pop_front());
    while (wr_q.size() != 0 && wr_q[0] < cyc) void'(wr_q.pop_front());
    rdv = (exp_q.size() != 0) && (int'(exp_q[0]) <= cyc);
    wrd = 0;
    foreach (wr_q[i]) if (wr_q[i] == cyc) wrd = 1;
    for (int i = 0; i < NB; i++) bo[i] = m_open[i];
    return {rdv, wrd, exp_viol, 4'(exp_code), bo, exp_ovf};
  endfunction

  task automatic do_reset();
    rst = 1; cmd_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // Drives one command cycle and advances the model to the following cycle.
  task automatic step(input bit v, input int op, input int b);
    cmd_valid = v; cmd_op = 2'(op); cmd_bank = 2'(b); cmd_row = 16'($urandom);
    @(posedge clk); #1;
    model_apply(v, op, b);
    cyc++;
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; #1;
    n_vec++;
    if (obs !== 12'd0) begin n_err++; $display("FAIL reset_hold got=%b exp=%b", obs, 12'd0); end
    do_reset();
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL reset_release got=%b exp=%b", obs, exp_vec()); end
  endtask

  task automatic test_rd_basic();
    do_reset();
    for (int t = 0; t < 180; t++) begin
      step(t == 0 || t == 76, (t == 0) ? 0 : 1, 0);
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL rd_basic cyc=%0d got=%b exp=%b", cyc, obs, exp_vec()); end
      if (cyc == 156 || cyc == 157 || cyc == 172 || cyc == 173) begin
        n_vec++;
        if (rd_data_valid !== (cyc == 157 || cyc == 172)) begin
          n_err++; $display("FAIL rd_basic_edge cyc=%0d got=%b", cyc, rd_data_valid);
        end
      end
    end
  endtask

  task automatic test_trcd();
    do_reset();
    for (int t = 0; t < 160; t++) begin
      step(t == 0 || t == 50, (t == 0) ? 0 : 1, 0);
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL trcd cyc=%0d got=%b exp=%b", cyc, obs, exp_vec()); end
      if (cyc == 51) begin
        n_vec++;
        if (viol !== 1'b1 || viol_code !== 4'd6) begin
          n_err++; $display("FAIL trcd_code got=%b/%0d exp=1/6", viol, viol_code);
        end
      end
    end
  endtask

  task automatic test_rrd();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int t = 0; t < 30; t++) begin
        step(t == 0 || t == ((pass == 0) ? 10 : 22), 0, (t == 0) ? 0 : 1);
        n_vec++;
        if (obs !== exp_vec()) begin n_err++; $display("FAIL rrd p%0d cyc=%0d got=%b exp=%b", pass, cyc, obs, exp_vec()); end
      end
      n_vec++;
      if (pass == 0 && viol_code !== 4'd5) begin n_err++; $display("FAIL rrd_code got=%0d exp=5", viol_code); end
      else if (pass == 1 && (bank_open !== 4'b0011 || viol_code !== 4'd0)) begin
        n_err++; $display("FAIL rrd_clean got=%b/%0d exp=0011/0", bank_open, viol_code);
      end
    end
  endtask

  task automatic test_pre_wr();
    for (int pass = 0; pass < 2; pass++) begin
      int pre_t = (pass == 0) ? 200 : 228;
      do_reset();
      for (int t = 0; t < 240; t++) begin
        step(t == 0 || t == 76 || t == pre_t, (t == 0) ? 0 : (t == 76) ? 2 : 3, 0);
        n_vec++;
        if (obs !== exp_vec()) begin n_err++; $display("FAIL pre_wr p%0d cyc=%0d got=%b exp=%b", pass, cyc, obs, exp_vec()); end
        if (cyc == 168) begin
          n_vec++;
          if (wr_done !== 1'b1) begin n_err++; $display("FAIL wr_done_168 got=%b exp=1", wr_done); end
        end
        if (cyc == pre_t + 1) begin
          n_vec++;
          if (pass == 0 && (viol !== 1'b1 || viol_code !== 4'd13)) begin
            n_err++; $display("FAIL pre_code got=%b/%0d exp=1/13", viol, viol_code);
          end else if (pass == 1 && (viol !== 1'b0 || bank_open[0] !== 1'b0)) begin
            n_err++; $display("FAIL pre_clean got=%b/%b exp=0/0", viol, bank_open[0]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    do_reset();
    hi = 0;
    for (int t = 0; t < 270; t++) begin
      bit rd = (t >= 76) && (t <= 164) && ((t - 76) % 22 == 0);
      step(t == 0 || rd, (t == 0) ? 0 : 1, 0);
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs, exp_vec()); end
      if (rd_data_valid === 1'b1) hi++;
    end
    n_vec++;
    if (hi != 80 || rdq_overflow !== 1'b0) begin
      n_err++; $display("FAIL b2b_total got=%0d/%b exp=80/0", hi, rdq_overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int t = 0; t < 300; t++) begin
      step(t == 0 || (t >= 76 && t <= 84), (t == 0) ? 0 : 1, 0);
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL ovf cyc=%0d got=%b exp=%b", cyc, obs, exp_vec()); end
    end
`ifndef DDR5_DROP_ILLEGAL_EN
    n_vec++;
    if (rdq_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", rdq_overflow); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int t = 0; t < 160; t++) step(t == 0 || t == 76, (t == 0) ? 0 : 1, 0);
    n_vec++;
    if (rd_data_valid !== 1'b1) begin n_err++; $display("FAIL mid_burst_pre got=%b exp=1", rd_data_valid); end
    #2 rst = 1;
    #1;
    n_vec++;
    if (rd_data_valid !== 1'b0 || bank_open !== 4'b0000) begin
      n_err++; $display("FAIL mid_burst_abort got=%b/%b exp=0/0000", rd_data_valid, bank_open);
    end
    do_reset();
    step(1, 0, 0);
    n_vec++;
    if (viol !== 1'b0 || obs !== exp_vec()) begin
      n_err++; $display("FAIL post_reset_act got=%b exp=%b", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      bit v = ($urandom_range(0, 5) == 0);
      int op = $urandom_range(0, 3);
      int b = $urandom_range(0, NB - 1);
      if (op == 2 && wr_q.size() >= 5) op = 3;
      step(v, op, b);
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_vec()); end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    test_reset();
    test_rd_basic();
    test_trcd();
    test_rrd();
    test_pre_wr();
    test_back_to_back();
    test_overflow();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr5_dram_cmd_responder.md
Name: ddr5_dram_cmd_responder

Overview:
- DRAM-side model and timing checker at the far end of the memory scheduler's command interface; lives in the testbench-facing DDR5 subsystem.
- Accepts one ACT/RD/WR/PRE per cycle for a single bank group.
- Tracks per-bank open/closed state and row, and checks every command against the DDR5 timing set shared with the scheduler.
- Returns read-data-valid and write-complete strobes at protocol latency, and flags violations with a code.

Parameters:
- NUM_BANKS, 4, banks in the group (power of 2, 2..8).
- ROW_W, 16, row address width.
- RDQ_DEPTH, 8, outstanding-read tracking depth (power of 2).
- T_RC/T_RAS/T_RRD_L/T_RP/T_RCD, 228/152/22/76/76, cycles.
- T_CL/T_CWD/T_WR/T_RTP/T_BURST, 80/76/60/36/16, cycles.
- T_CCD_L/T_CCD_L_WR/T_CCD_L_RTW/T_CCD_L_WTR, 22/94/30/138, cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present this cycle.
- cmd_op  in  2  0=ACT, 1=RD, 2=WR, 3=PRE.
- cmd_bank  in  $clog2(NUM_BANKS)  target bank.
- cmd_row  in  ROW_W  row (ACT only).
- rd_data_valid  out  1  high for T_BURST cycles per read burst.
- wr_done  out  1  one-cycle pulse per completed write.
- viol  out  1  one-cycle pulse on a timing/state violation.
- viol_code  out  4  cause, held until the next violation.
- bank_open  out  NUM_BANKS  per-bank active flag.
- rdq_overflow  out  1  sticky; read tracker overflowed.

Behaviour:
- Async reset: all banks CLOSED, bank_open=0, rd_data_valid=0, wr_done=0, viol=0, viol_code=0, rdq_overflow=0, tracker empty.
- Reset also presets all elapsed counters to saturated, so the first command after reset never violates timing.
- Reset mid-burst aborts everything immediately.
- Per-bank FSM: CLOSED -ACT-> OPEN; OPEN -PRE-> CLOSED.
- Other commands do not change state, except as noted under the optional feature.
- Counters: per bank, cycles since last ACT, PRE, RD and WR-issue; one group counter since last ACT and since last RD/WR to any bank.
  - 10-bit, saturating at 1023, cleared to 0 on the cycle the event is accepted.
  - Compare as elapsed >= T_x.
- Violation codes (lowest code wins if several apply):
  - 1: ACT to OPEN bank.
  - 2: RD/WR/PRE... RD/WR to CLOSED bank.
  - 3: ACT before T_RP after PRE.
  - 4: ACT before T_RC after ACT, same bank.
  - 5: ACT before T_RRD_L after any ACT.
  - 6: RD/WR before T_RCD after ACT.
  - 7: RD before T_CCD_L after RD.
  - 8: WR before T_CCD_L_WR after WR.
  - 9: WR before T_CCD_L_RTW after RD.
  - 10: RD before T_CCD_L_WTR after WR.
  - 11: PRE before T_RAS after ACT.
  - 12: PRE before T_RTP after RD.
  - 13: PRE before T_CWD+T_BURST+T_WR after WR.
- PRE to a CLOSED bank is legal and a no-op.
- viol asserts the cycle after the offending command is sampled.
- Read return:
  - Each accepted RD pushes (free-running 16-bit timestamp + T_CL) into the tracker.
  - When the timestamp matches the head entry, pop it and drive rd_data_valid for T_BURST cycles.
  - Back-to-back bursts merge seamlessly.
  - Push on full: the RD is dropped from the tracker and rdq_overflow is set.
  - Push and pop in the same cycle while full is allowed.
- Write: wr_done pulses T_CWD+T_BURST cycles after the WR cycle, via a second identical tracker.
- cmd_valid=0: counters advance, no state change.

Optional Feature:
- Macro: DDR5_DROP_ILLEGAL_EN.
- Defined: a violating command is flagged and otherwise ignored. No state change, no counter clear, no tracker push.
- Undefined: a violating command is flagged and still executed as if legal, so downstream data strobes still appear.

Test Plan:
- Reset, ACT b0 at t=0, RD b0 at t=76 -> no viol; rd_data_valid high cycles 157..172 (T_CL=80 after the RD-issue sample edge, 16 cycles).
- ACT b0 t=0, RD b0 t=50 -> viol at t=51, viol_code=6; with DDR5_DROP_ILLEGAL_EN there is no rd_data_valid.
- ACT b0 t=0, ACT b1 t=10 -> viol_code=5; ACT b1 at t=22 instead -> clean, bank_open=4'b0011.
- ACT b0 t=0, WR t=76, PRE t=200 -> viol_code=13 (needs >=228); PRE t=228 -> clean, bank_open[0]=0; wr_done pulse at t=168.
- Five RDs 22 cycles apart on an open bank -> 5 contiguous bursts of 16, gaps of 6 idle cycles, no overflow. Nine RDs with RDQ_DEPTH=8 while head not yet due -> rdq_overflow=1.
- Assert rst mid-burst -> rd_data_valid drops asynchronously, bank_open=0; ACT immediately after release -> no viol.
